// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Conditions raw slide-switch levels before core logic or LEDs consume
//   them. Each bit passes through a SYNC_STAGES-deep synchronizer and then a
//   counter-based debouncer. A new level is accepted only after it has held
//   for STABLE_CYCLES consecutive synchronized cycles.
//
// Parameters
//   WIDTH          number of switch bits
//   SYNC_STAGES    synchronizer depth (>= 2)
//   STABLE_CYCLES  consecutive cycles a new level must hold (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   sw_in     raw asynchronous switch levels
//   sw_out    debounced switch levels (registered)
//   sw_chg    one-cycle strobe per bit when sw_out[i] changes
//   sw_valid  sticky; high once sw_out reflects inputs sampled since reset
// ---------------------------------------------------------------------------
module sw_debounce #(
    parameter int WIDTH         = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_chg,
    output logic             sw_valid
);

    // Per-bit stability counter.
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Valid counter: sw_valid rises together with the first possible
    // debounced update after reset, so the counter must reach the full
    // synchronizer-plus-debounce latency.
    localparam int VALID_AT = SYNC_STAGES + STABLE_CYCLES - 1;
    localparam int VW       = $clog2(VALID_AT + 1);
    localparam logic [VW-1:0] VCNT_LAST = VW'(VALID_AT);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] chg_next;
    logic [VW-1:0]    vcnt_reg;

    // -----------------------------------------------------------------------
    // Synchronizer chain
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= '0;
            end
        end else begin
            sync_reg[0] <= sw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
        end
    end

    assign sync_s = sync_reg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Per-bit debouncers. Each bit owns its counter; the bit's next output
    // and strobe are computed here and registered below as whole vectors.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          mismatch;
            logic          done;

            assign mismatch = sync_s[gi] ^ sw_out[gi];
            // Accept on the STABLE_CYCLES-th consecutive mismatching cycle.
            assign done     = mismatch && (cnt_reg == CNT_LAST);

            // Any cycle that agrees with the current output throws away all
            // progress, so a glitch can never earn partial credit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (!mismatch || done) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign out_next[gi] = done ? sync_s[gi] : sw_out[gi];
            assign chg_next[gi] = done;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output registers. sw_chg is rewritten every cycle, so a strobe lasts
    // exactly one cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_out <= '0;
            sw_chg <= '0;
        end else begin
            sw_out <= out_next;
            sw_chg <= chg_next;
        end
    end

    // -----------------------------------------------------------------------
    // Post-reset valid flag: saturating counter, sticky flag.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcnt_reg <= '0;
            sw_valid <= 1'b0;
        end else begin
            if (vcnt_reg != VCNT_LAST) begin
                vcnt_reg <= vcnt_reg + 1'b1;
            end
            if (vcnt_reg == VCNT_LAST) begin
                sw_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//   Directed bench for sw_debounce at default parameters (WIDTH=10,
//   SYNC_STAGES=2, STABLE_CYCLES=16 -> 18-edge latency). Inputs are driven
//   1 time unit after a rising edge, and outputs are sampled at that same
//   point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

    logic        clk;
    logic        rst;
    logic [9:0]  sw_in;
    logic [9:0]  sw_out;
    logic [9:0]  sw_chg;
    logic        sw_valid;

    int checks;
    int errors;

    sw_debounce #(
        .WIDTH         (10),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .sw_out   (sw_out),
        .sw_chg   (sw_chg),
        .sw_valid (sw_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("check %s ok: %0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [9:0] prev_v;
    logic [9:0] new_v;
    int         pulses;
    int         strobe_edge;
    int         other_bad;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        sw_in  = 10'h2A5;

        // ---- 1: reset with 2A5 held, then release ----
        #3;
        check("t1_rst_out", 32'(sw_out), 32'h0);
        check("t1_rst_valid", 32'(sw_valid), 32'h0);
        steps(2);
        rst = 1'b0;
        steps(17);
        check("t1_e17_out", 32'(sw_out), 32'h0);
        check("t1_e17_valid", 32'(sw_valid), 32'h0);
        step();
        check("t1_e18_out", 32'(sw_out), 32'h2A5);
        check("t1_e18_chg", 32'(sw_chg), 32'h2A5);
        check("t1_e18_valid", 32'(sw_valid), 32'h1);
        step();
        check("t1_e19_chg", 32'(sw_chg), 32'h0);
        check("t1_e19_valid", 32'(sw_valid), 32'h1);

        // ---- 2: step 2A5 -> 15A ----
        steps(5);
        sw_in = 10'h15A;
        steps(17);
        check("t2_e17_out", 32'(sw_out), 32'h2A5);
        check("t2_e17_chg", 32'(sw_chg), 32'h0);
        step();
        check("t2_e18_out", 32'(sw_out), 32'h15A);
        check("t2_e18_chg", 32'(sw_chg), 32'h3FF);
        step();
        check("t2_e19_chg", 32'(sw_chg), 32'h0);

        // ---- 3: 15-cycle pulse on bit3 is rejected ----
        steps(3);
        other_bad = 0;
        sw_in = 10'h15A ^ 10'h008;
        for (int i = 0; i < 15; i++) begin
            step();
            if (sw_chg != 10'h0 || sw_out != 10'h15A) other_bad++;
        end
        sw_in = 10'h15A;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sw_chg != 10'h0 || sw_out != 10'h15A) other_bad++;
        end
        check("t3_glitch15_quiet", 32'(other_bad), 32'h0);

        // ---- 3b: 16-cycle pulse on bit3 flips out and back ----
        pulses    = 0;
        other_bad = 0;
        sw_in = 10'h15A ^ 10'h008;
        for (int i = 0; i < 16; i++) begin
            step();
            if (sw_chg[3]) pulses++;
            if ((sw_chg & 10'h3F7) != 10'h0) other_bad++;
        end
        sw_in = 10'h15A;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sw_chg[3]) pulses++;
            if ((sw_chg & 10'h3F7) != 10'h0) other_bad++;
        end
        check("t3b_bit3_pulses", 32'(pulses), 32'd2);
        check("t3b_other_bits", 32'(other_bad), 32'h0);
        check("t3b_final_out", 32'(sw_out), 32'h15A);

        // ---- 4: bit0 chatter, then settle at 1 ----
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            sw_in[0] = ~sw_in[0];
            for (int i = 0; i < 5; i++) begin
                step();
                if (sw_chg != 10'h0) pulses++;
            end
        end
        check("t4_chatter_quiet", 32'(pulses), 32'h0);
        sw_in[0]    = 1'b1;
        strobe_edge = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (sw_chg[0]) begin
                pulses++;
                strobe_edge = i;
            end
        end
        check("t4_strobe_count", 32'(pulses), 32'd1);
        check("t4_strobe_edge", 32'(strobe_edge), 32'd18);
        check("t4_final_out", 32'(sw_out), 32'h15B);

        // ---- 5: async reset while bit1 is mid-count (cnt=10) ----
        sw_in = 10'h159;
        steps(12);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_out", 32'(sw_out), 32'h0);
        check("t5_async_chg", 32'(sw_chg), 32'h0);
        check("t5_async_valid", 32'(sw_valid), 32'h0);
        steps(2);
        rst = 1'b0;
        steps(17);
        check("t5_e17_out", 32'(sw_out), 32'h0);
        check("t5_e17_valid", 32'(sw_valid), 32'h0);
        step();
        check("t5_e18_out", 32'(sw_out), 32'h159);
        check("t5_e18_chg", 32'(sw_chg), 32'h159);
        check("t5_e18_valid", 32'(sw_valid), 32'h1);

        // ---- 6: random vectors, 30-cycle holds ----
        steps(3);
        prev_v = 10'h159;
        for (int v = 0; v < 10; v++) begin
            new_v  = 10'($urandom_range(0, 1023));
            sw_in  = new_v;
            pulses = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                pulses += $countones(sw_chg);
            end
            check($sformatf("t6_v%0d_out", v), 32'(sw_out), 32'(new_v));
            check($sformatf("t6_v%0d_pulses", v), 32'(pulses), 32'($countones(prev_v ^ new_v)));
            prev_v = new_v;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
